// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC feeder: sample geometry,
// gain scaling and the mute-ramp state encoding.
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int DATA_WIDTH = 32;
    localparam int GAIN_W     = 9;
    localparam int GAIN_SHIFT = 7;

    localparam logic [7:0] UNITY_GAIN = 8'd128;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/audio_gain_sat.sv
// One channel of the second pipeline stage: signed sample times unsigned gain,
// arithmetic shift by GAIN_SHIFT, then saturation to the sample range.
module audio_gain_sat #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic signed [SAMPLE_W-1:0]       sample,
    input  logic [audio_pkg::GAIN_W-1:0]     gain,
    output logic [SAMPLE_W-1:0]              result,
    output logic                             clip
);
    import audio_pkg::*;

    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] shifted_s;
    logic                     in_range_s;

    assign prod_s     = PROD_W'(sample) * PROD_W'($signed({1'b0, gain}));
    assign shifted_s  = prod_s >>> GAIN_SHIFT;
    // In range when every bit above the sample sign bit matches it.
    assign in_range_s = (shifted_s[PROD_W-1:SAMPLE_W-1] ==
                         {(PROD_W-SAMPLE_W+1){shifted_s[PROD_W-1]}});

    // Saturate out-of-range products toward the sign of the product.
    always_comb begin
        result = shifted_s[SAMPLE_W-1:0];
        clip   = 1'b0;
        if (!in_range_s) begin
            clip   = 1'b1;
            result = shifted_s[PROD_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            clip   = 1'b0;
            result = shifted_s[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/audio_dac_feeder.sv
// Volume/mute-ramp stage feeding the DAC FIFO: two-stage pipeline with stall on full.
// Optional clip counter enabled by defining AUDIO_DAC_FEEDER_CLIP_CNT_EN.
module audio_dac_feeder #(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int DATA_WIDTH = audio_pkg::DATA_WIDTH,
    parameter int RAMP_STEP  = 1
) (
    input  logic                  dacfifo_wrclk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMPLE_W-1:0]   s_left,
    input  logic [SAMPLE_W-1:0]   s_right,
    input  logic [7:0]            vol,
    input  logic                  mute,
    output logic                  dacfifo_wren,
    output logic [DATA_WIDTH-1:0] dacfifo_wrdata,
    input  logic                  dacfifo_full,
    output logic                  muted,
    output logic                  clip,
    output logic [15:0]           clip_cnt
);
    import audio_pkg::*;

    ramp_state_t state_r, state_next_s, up_state_s, down_state_s;
    logic [7:0]  ramp_r, ramp_next_s, up_ramp_s, down_ramp_s;
    logic [8:0]  ramp_sum_s;
    logic        advance_s, accept_s, muted_r;
    logic [GAIN_W-1:0] gain_s, s1_gain_r;

    logic                       s1_valid_r, out_valid_r, clip_r;
    logic signed [SAMPLE_W-1:0] s1_left_r, s1_right_r;
    logic [SAMPLE_W-1:0]        left_res_s, right_res_s;
    logic                       clip_left_s, clip_right_s;
    logic [DATA_WIDTH-1:0]      wrdata_r;

    assign advance_s = ~(out_valid_r & dacfifo_full);
    assign accept_s  = s_valid & advance_s;
    assign gain_s    = GAIN_W'(({8'd0, vol} * {8'd0, ramp_r}) >> GAIN_SHIFT);
    assign ramp_sum_s = {1'b0, ramp_r} + 9'(RAMP_STEP);

    // Candidate ramp values one step up or down, clamped to 0..UNITY_GAIN.
    always_comb begin
        up_ramp_s    = ramp_sum_s[7:0];
        up_state_s   = RAMP_UP;
        down_ramp_s  = 8'd0;
        down_state_s = MUTED;
        if (ramp_sum_s >= {1'b0, UNITY_GAIN}) begin
            up_ramp_s  = UNITY_GAIN;
            up_state_s = ACTIVE;
        end else begin
            up_ramp_s  = ramp_sum_s[7:0];
            up_state_s = RAMP_UP;
        end
        if (ramp_r <= 8'(RAMP_STEP)) begin
            down_ramp_s  = 8'd0;
            down_state_s = MUTED;
        end else begin
            down_ramp_s  = ramp_r - 8'(RAMP_STEP);
            down_state_s = RAMP_DOWN;
        end
    end

    // Ramp FSM next state; moves only on an accepted pair, direction set by mute.
    always_comb begin
        state_next_s = state_r;
        ramp_next_s  = ramp_r;
        if (accept_s) begin
            case (state_r)
                MUTED: begin
                    if (!mute) begin
                        state_next_s = up_state_s;
                        ramp_next_s  = up_ramp_s;
                    end else begin
                        state_next_s = MUTED;
                        ramp_next_s  = 8'd0;
                    end
                end
                ACTIVE: begin
                    if (mute) begin
                        state_next_s = down_state_s;
                        ramp_next_s  = down_ramp_s;
                    end else begin
                        state_next_s = ACTIVE;
                        ramp_next_s  = UNITY_GAIN;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (mute) begin
                        state_next_s = down_state_s;
                        ramp_next_s  = down_ramp_s;
                    end else begin
                        state_next_s = up_state_s;
                        ramp_next_s  = up_ramp_s;
                    end
                end
                default: begin
                    state_next_s = MUTED;
                    ramp_next_s  = 8'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
            ramp_next_s  = ramp_r;
        end
    end

    // Ramp FSM state register and registered muted flag.
    always_ff @(posedge dacfifo_wrclk) begin
        if (!reset_n) begin
            state_r <= MUTED;
            ramp_r  <= 8'd0;
            muted_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            ramp_r  <= ramp_next_s;
            muted_r <= (state_next_s == MUTED);
        end
    end

    audio_gain_sat #(.SAMPLE_W(SAMPLE_W)) u_gain_left (
        .sample (s1_left_r),
        .gain   (s1_gain_r),
        .result (left_res_s),
        .clip   (clip_left_s)
    );

    audio_gain_sat #(.SAMPLE_W(SAMPLE_W)) u_gain_right (
        .sample (s1_right_r),
        .gain   (s1_gain_r),
        .result (right_res_s),
        .clip   (clip_right_s)
    );

    // Two-stage pipeline; everything holds while the output word waits on full.
    always_ff @(posedge dacfifo_wrclk) begin
        if (!reset_n) begin
            s1_valid_r  <= 1'b0;
            s1_left_r   <= '0;
            s1_right_r  <= '0;
            s1_gain_r   <= '0;
            out_valid_r <= 1'b0;
            wrdata_r    <= '0;
            clip_r      <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r  <= s_valid;
            s1_left_r   <= s_left;
            s1_right_r  <= s_right;
            s1_gain_r   <= gain_s;
            out_valid_r <= s1_valid_r;
            wrdata_r    <= {left_res_s, right_res_s};
            clip_r      <= s1_valid_r & (clip_left_s | clip_right_s);
        end else begin
            clip_r      <= 1'b0;
        end
    end

`ifdef AUDIO_DAC_FEEDER_CLIP_CNT_EN
    logic [15:0] clip_cnt_r;

    // Saturating count of clip pulses, cleared only by reset.
    always_ff @(posedge dacfifo_wrclk) begin
        if (!reset_n) begin
            clip_cnt_r <= 16'd0;
        end else if (clip_r && (clip_cnt_r != 16'hFFFF)) begin
            clip_cnt_r <= clip_cnt_r + 16'd1;
        end else begin
            clip_cnt_r <= clip_cnt_r;
        end
    end

    assign clip_cnt = clip_cnt_r;
`else
    assign clip_cnt = 16'd0;
`endif

    assign s_ready        = advance_s;
    assign dacfifo_wren   = out_valid_r & ~dacfifo_full;
    assign dacfifo_wrdata = wrdata_r;
    assign muted          = muted_r;
    assign clip           = clip_r;

endmodule

// File: tb/tb_audio_dac_feeder.sv
// Scoreboard bench for audio_dac_feeder: directed pairs push expected words,
// a monitor pops and compares on every FIFO write.
module tb_audio_dac_feeder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_left = 16'd0;
    logic [15:0] s_right = 16'd0;
    logic [7:0]  vol = 8'd128;
    logic        mute = 1'b1;
    logic        dacfifo_wren;
    logic [31:0] dacfifo_wrdata;
    logic        dacfifo_full = 1'b0;
    logic        muted;
    logic        clip;
    logic [15:0] clip_cnt;

    typedef struct {
        logic [31:0] data;
        logic        clip;
        logic        chk;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    int   clip_seen = 0;
    int   clip_before;

    audio_dac_feeder dut (
        .dacfifo_wrclk  (clk),
        .reset_n        (reset_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_left         (s_left),
        .s_right        (s_right),
        .vol            (vol),
        .mute           (mute),
        .dacfifo_wren   (dacfifo_wren),
        .dacfifo_wrdata (dacfifo_wrdata),
        .dacfifo_full   (dacfifo_full),
        .muted          (muted),
        .clip           (clip),
        .clip_cnt       (clip_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the oldest expected word.
    always @(negedge clk) begin
        if (clip) clip_seen++;
        if (dacfifo_wren) begin
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write: got=%h expected=none", dacfifo_wrdata);
            end else begin
                mon_e = sb.pop_front();
                if (dacfifo_wrdata !== mon_e.data) begin
                    errs++;
                    $display("FAIL wrdata: got=%h expected=%h", dacfifo_wrdata, mon_e.data);
                end
                if (mon_e.chk) begin
                    checks++;
                    if (clip !== mon_e.clip) begin
                        errs++;
                        $display("FAIL clip_pulse: got=%b expected=%b", clip, mon_e.clip);
                    end
                    checks++;
                    if (cyc - mon_e.acc != 2) begin
                        errs++;
                        $display("FAIL latency: got=%0d expected=2", cyc - mon_e.acc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input logic [31:0] exp, input logic exp_clip, input logic chk);
        int   waits = 0;
        logic done = 1'b0;
        exp_t e;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin
                e.data = exp; e.clip = exp_clip; e.chk = chk; e.acc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end else if (++waits > 50) begin
                checks++;
                errs++;
                $display("FAIL accept_timeout: got=stalled expected=accept");
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain: got=%0d pending expected=0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lv, rv;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wren", {31'd0, dacfifo_wren}, 32'd0);
        check("rst_wrdata", dacfifo_wrdata, 32'd0);
        check("rst_muted", {31'd0, muted}, 32'd1);
        check("rst_clip", {31'd0, clip}, 32'd0);
        check("rst_clip_cnt", {16'd0, clip_cnt}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mute = 1'b0;
        vol  = 8'd128;

        // Linear ramp up: pair k uses gain k
        for (int k = 0; k < 128; k++) begin
            lv = 16'(32 * k);
            rv = 16'(-32 * k);
            send(16'h1000, 16'hF000, {lv, rv}, 1'b0, 1'b1);
            if (k == 0) check("muted_after_first", {31'd0, muted}, 32'd0);
        end
        for (int k = 0; k < 4; k++) send(16'h1000, 16'hF000, 32'h1000F000, 1'b0, 1'b1);
        drain();

        // Saturation at vol=255
        vol = 8'd255;
        for (int k = 0; k < 4; k++) send(16'h7000, 16'h8000, 32'h7FFF8000, 1'b1, 1'b1);
        drain();
`ifdef AUDIO_DAC_FEEDER_CLIP_CNT_EN
        check("clip_cnt", {16'd0, clip_cnt}, 32'd4);
`else
        check("clip_cnt", {16'd0, clip_cnt}, 32'd0);
`endif

        // Backpressure: full held 10 cycles mid-stream
        vol = 8'd128;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    lv = 16'h0100 + 16'(i);
                    rv = 16'hC000 - 16'(i);
                    send(lv, rv, {lv, rv}, 1'b0, 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                dacfifo_full = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("full_s_ready", {31'd0, s_ready}, 32'd0);
                    check("full_wren", {31'd0, dacfifo_wren}, 32'd0);
                    @(posedge clk); #1;
                end
                dacfifo_full = 1'b0;
                @(negedge clk);
                check("full_release_wren", {31'd0, dacfifo_wren}, 32'd1);
            end
        join
        drain();

        // Ramp up to 64, then mute ramps down to zero
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        mute = 1'b0;
        for (int k = 0; k < 64; k++) begin
            lv = 16'(32 * k);
            rv = 16'(-32 * k);
            send(16'h1000, 16'hF000, {lv, rv}, 1'b0, 1'b1);
        end
        mute = 1'b1;
        for (int j = 0; j < 64; j++) begin
            lv = 16'(32 * (64 - j));
            rv = 16'(-32 * (64 - j));
            if (j == 63) check("muted_before_zero", {31'd0, muted}, 32'd0);
            send(16'h1000, 16'hF000, {lv, rv}, 1'b0, 1'b1);
        end
        check("muted_at_zero", {31'd0, muted}, 32'd1);
        for (int k = 0; k < 2; k++) send(16'h1000, 16'hF000, 32'h00000000, 1'b0, 1'b1);
        drain();

        // Reset during a stall discards in-flight pairs
        mute = 1'b0;
        send(16'h1234, 16'h4321, 32'h0, 1'b0, 1'b0);
        send(16'h1234, 16'h4321, 32'h0, 1'b0, 1'b0);
        dacfifo_full = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_wren", {31'd0, dacfifo_wren}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        dacfifo_full = 1'b0;
        @(negedge clk);
        check("post_rst_wren", {31'd0, dacfifo_wren}, 32'd0);
        check("post_rst_muted", {31'd0, muted}, 32'd1);
        check("post_rst_clip_cnt", {16'd0, clip_cnt}, 32'd0);
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("post_rst_wrdata", dacfifo_wrdata, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // vol=0 gives silence in every state, never clips
        clip_before = clip_seen;
        vol  = 8'd0;
        mute = 1'b0;
        for (int k = 0; k < 128; k++) send(16'h7FFF, 16'h8000, 32'h00000000, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            lv = 16'($urandom);
            rv = 16'($urandom);
            send(lv, rv, 32'h00000000, 1'b0, 1'b1);
        end
        drain();
        check("vol0_no_clip", 32'(clip_seen - clip_before), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
